rtf65002_itagmem_assoc: RTL and testbench
=========================================

Name: rtf65002_itagmem_assoc

Overview:
- Parametrised, set-associative instruction-cache tag store; the next generation of the fixed 4 KB direct-mapped tag RAM.
- Does two lookups per clock: the fetch PC and PC+NEXT_OFS, so a fetch that spans two lines is detected.
- Has per-set round-robin replacement, single-line invalidate, and a sequenced invalidate-all sweep that also runs after reset.
- Sits between the fetch unit and the I-cache fill controller; the fill controller uses hit_way/wr_way to address the data RAM.

Parameters:
- AW, 32, byte-address width.
- LINE_BYTES, 16, bytes per line (power of 2, >=8).
- SETS, 256, sets per way (power of 2).
- WAYS, 2, associativity (1, 2 or 4).
- NEXT_OFS, 8, byte offset of the second lookup.
- Derived:
  - LOB = log2(LINE_BYTES)
  - SB = log2(SETS)
  - WB = max(1, log2(WAYS))
  - TAGW = AW-LOB-SB

Ports:
- clk  in  1  single clock for all lookups, writes and the sweep.
- rst_n  in  1  asynchronous reset, active low.
- pc  in  AW  fetch address for lookup 0.
- hit0  out  1  line holding pc is present (registered).
- hit0_way  out  WB  way that hit for pc.
- hit1  out  1  line holding pc+NEXT_OFS is present (registered).
- hit1_way  out  WB  way that hit for pc+NEXT_OFS.
- wr  in  1  fill write strobe.
- adr  in  AW  fill address.
- wr_way  out  WB  victim way for adr's set (combinational, valid every cycle).
- inv_line  in  1  invalidate the line containing adr in all ways.
- inv_all  in  1  start the invalidate-all sweep.
- busy  out  1  sweep in progress.

Behaviour:
- Storage:
  - Per way, a SETS x (TAGW+1) synchronous RAM holding {tag, valid}.
  - Per set, a WB-bit round-robin pointer in flops.
- Index and tag: set index = addr[LOB+SB-1:LOB]; tag = addr[AW-1:LOB+SB].
- Lookup:
  - Read-address the RAMs with the set of pc and of pcp = pc+NEXT_OFS (AW-bit add, wraps modulo 2^AW).
  - Register pc and pcp.
  - On the next cycle, hitN = OR over ways of (valid && stored tag == registered tag).
  - Latency is exactly 1 clock; hitN_way is the lowest-numbered matching way, 0 when there is no hit.
- Fill write:
  - A tag write occurs when wr=1, busy=0, and adr[LOB-1:2] is all ones (last word of the line).
  - Writes {adr tag, valid=1} into way wr_way at adr's set, then advances that set's pointer by 1 modulo WAYS.
  - wr=1 on any other word offset changes nothing.
  - The fill controller only fills on a miss; no duplicate-tag check is made.
- Line invalidate: inv_line=1 with busy=0 clears valid in every way at adr's set whose tag equals adr's tag. Other ways are untouched and the pointer is unchanged.
- Priority in one cycle: inv_all > inv_line > wr. The lower-priority request is dropped.
- Read/write ordering: a lookup and a write/invalidate to the same set in the same cycle returns the pre-write contents. The effect is visible to lookups issued from the next cycle on.
- Sweep FSM:
  - States: IDLE, SWEEP.
  - Reset asserted: state=SWEEP, counter=0, busy=1, hit0=hit1=0, hit0_way=hit1_way=0.
  - SWEEP: each cycle, write {0, valid=0} to every way at set=counter and clear that set's pointer, then increment the counter.
  - After writing set SETS-1, go to IDLE; busy falls the cycle after the last set is cleared. Sweep length is SETS cycles.
  - inv_all in IDLE enters SWEEP at counter 0 on the next edge. inv_all during SWEEP restarts the counter at 0.
  - While busy=1: hit0=hit1=0 (forced in the output register), and wr and inv_line are ignored.
  - Reset mid-sweep restarts from set 0.
- WAYS=1: wr_way is constant 0 and the pointer flops are removed.

Test Plan:
- Reset release, no stimulus -> busy=1 for exactly 256 cycles then 0; hit0=hit1=0 throughout; every pc lookup afterwards misses.
- After the sweep, wr with adr=0x0000_123C -> wr_way=0; next-cycle lookup pc=0x0000_1230 -> one cycle later hit0=1, hit0_way=0; pc=0x0000_2230 -> hit0=0.
- Fill 0x0000_123C then 0x0000_523C (same set 0x23) -> wr_way 0 then 1, both hit. A third fill 0x0000_923C goes to way 0, evicts 0x1230's tag; 0x5230 still hits in way 1.
- pc=0x0000_1238 with 0x1230 and 0x1240 lines filled -> hit0=1 and hit1=1; with only 0x1230 filled -> hit0=1, hit1=0.
- inv_line adr=0x0000_5230 -> 0x5230 misses, 0x9230 still hits. Same cycle as a lookup of 0x5230 -> that lookup still hits (old data), the following one misses.
- inv_all at cycle 100 of a sweep -> busy stays high 256 more cycles. wr and inv_line together with inv_all -> no tag written; all lookups miss after the sweep.

Source files
------------

// File: rtl/rtf65002_itagmem_assoc.sv
// Set-associative I-cache tag store: dual lookup (pc and pc+NEXT_OFS), round-robin fill,
// line invalidate and an invalidate-all sweep that also runs out of reset.
module rtf65002_itagmem_assoc #(
    parameter int AW         = 32,
    parameter int LINE_BYTES = 16,
    parameter int SETS       = 256,
    parameter int WAYS       = 2,
    parameter int NEXT_OFS   = 8,
    localparam int WB        = (WAYS > 1) ? $clog2(WAYS) : 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [AW-1:0] pc,
    output logic          hit0,
    output logic [WB-1:0] hit0_way,
    output logic          hit1,
    output logic [WB-1:0] hit1_way,
    input  logic          wr,
    input  logic [AW-1:0] adr,
    output logic [WB-1:0] wr_way,
    input  logic          inv_line,
    input  logic          inv_all,
    output logic          busy
);
    localparam int LOB  = $clog2(LINE_BYTES);
    localparam int SB   = $clog2(SETS);
    localparam int TAGW = AW - LOB - SB;

    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_SWEEP = 1'b1;

    // One {tag, valid} word per set per way; lookups read synchronously.
    logic [TAGW:0]   mem [WAYS][SETS];
    logic [TAGW:0]   rd0 [WAYS];
    logic [TAGW:0]   rd1 [WAYS];

    logic [AW-1:0]   pcp;
    logic [SB-1:0]   set0, set1, aset;
    logic [TAGW-1:0] atag, tag0_q, tag1_q;
    logic            blank_q;
    logic [0:0]      state;
    logic [SB-1:0]   cnt;
    logic            do_inv, do_wr;
    logic            unused_bits;

    assign pcp  = pc + AW'(NEXT_OFS);
    assign set0 = pc[LOB+SB-1:LOB];
    assign set1 = pcp[LOB+SB-1:LOB];
    assign aset = adr[LOB+SB-1:LOB];
    assign atag = adr[AW-1:LOB+SB];
    assign unused_bits = ^{pc[LOB-1:0], pcp[LOB-1:0], adr[1:0]};

    assign busy   = (state == ST_SWEEP);
    assign do_inv = inv_line & ~inv_all & ~busy;
    assign do_wr  = wr & ~inv_line & ~inv_all & ~busy & (&adr[LOB-1:2]);

    generate
        if (WAYS > 1) begin : g_rr
            logic [WB-1:0] ptr [SETS];

            assign wr_way = ptr[aset];

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    for (int i = 0; i < SETS; i++) ptr[i] <= '0;
                end else if (busy) begin
                    ptr[cnt] <= '0;
                end else if (do_wr) begin
                    ptr[aset] <= ptr[aset] + 1'b1;
                end
            end
        end else begin : g_dm
            assign wr_way = '0;
        end
    endgenerate

    // Reads sample the pre-write contents; sweep > invalidate > fill.
    always_ff @(posedge clk) begin
        for (int w = 0; w < WAYS; w++) begin
            rd0[w] <= mem[w][set0];
            rd1[w] <= mem[w][set1];
            if (busy) begin
                mem[w][cnt] <= '0;
            end else if (do_inv && mem[w][aset] == {atag, 1'b1}) begin
                mem[w][aset] <= {atag, 1'b0};
            end else if (do_wr && wr_way == WB'(w)) begin
                mem[w][aset] <= {atag, 1'b1};
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= ST_SWEEP;
            cnt     <= '0;
            blank_q <= 1'b1;
            tag0_q  <= '0;
            tag1_q  <= '0;
        end else begin
            blank_q <= busy;
            tag0_q  <= pc[AW-1:LOB+SB];
            tag1_q  <= pcp[AW-1:LOB+SB];
            if (inv_all) begin
                state <= ST_SWEEP;
                cnt   <= '0;
            end else if (busy) begin
                cnt <= cnt + 1'b1;
                if (cnt == SB'(SETS - 1)) state <= ST_IDLE;
            end
        end
    end

    // Descending scan so the lowest-numbered matching way wins.
    always_comb begin
        hit0     = 1'b0;
        hit0_way = '0;
        hit1     = 1'b0;
        hit1_way = '0;
        for (int w = WAYS - 1; w >= 0; w--) begin
            if (!blank_q && rd0[w] == {tag0_q, 1'b1}) begin
                hit0     = 1'b1;
                hit0_way = WB'(w);
            end
            if (!blank_q && rd1[w] == {tag1_q, 1'b1}) begin
                hit1     = 1'b1;
                hit1_way = WB'(w);
            end
        end
    end
endmodule

// File: tb/tb_rtf65002_itagmem_assoc.sv
// Bench for rtf65002_itagmem_assoc: directed scenarios with literal expectations plus
// randomized traffic checked every cycle against a line-level model of the tag store.
module tb_rtf65002_itagmem_assoc;
    localparam int AW = 32;
    localparam int SETS = 256;
    localparam int WAYS = 2;
    localparam int WB = 1;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [AW-1:0] pc, adr;
    logic          wr, inv_line, inv_all;
    logic          hit0, hit1, busy;
    logic [WB-1:0] hit0_way, hit1_way, wr_way;

    int n_checks = 0;
    int n_fail = 0;

    rtf65002_itagmem_assoc dut (
        .clk(clk), .rst_n(rst_n), .pc(pc), .hit0(hit0), .hit0_way(hit0_way),
        .hit1(hit1), .hit1_way(hit1_way), .wr(wr), .adr(adr), .wr_way(wr_way),
        .inv_line(inv_line), .inv_all(inv_all), .busy(busy)
    );

    always #5 clk = ~clk;

    // Model: which tag each way holds per set, the fill pointer, and sweep cycles left.
    bit        m_valid [WAYS][SETS];
    logic [19:0] m_tag [WAYS][SETS];
    int        m_ptr [SETS];
    int        m_left;
    logic      e_hit0, e_hit1;
    int        e_way0, e_way1;

    function automatic int set_of(input logic [31:0] a);
        return int'(a[11:4]);
    endfunction

    function automatic void lookup(input logic [31:0] a, output logic h, output int w);
        h = 1'b0;
        w = 0;
        for (int i = 0; i < WAYS; i++) begin
            if (!h && m_valid[i][set_of(a)] && m_tag[i][set_of(a)] == a[31:12]) begin
                h = 1'b1;
                w = i;
            end
        end
    endfunction

    function automatic void clear_all();
        for (int s = 0; s < SETS; s++) begin
            m_ptr[s] = 0;
            for (int i = 0; i < WAYS; i++) m_valid[i][s] = 1'b0;
        end
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            clear_all();
            m_left = SETS;
            e_hit0 = 1'b0; e_hit1 = 1'b0; e_way0 = 0; e_way1 = 0;
        end else begin
            lookup(pc, e_hit0, e_way0);
            lookup(pc + 32'd8, e_hit1, e_way1);
            if (m_left > 0) begin
                e_hit0 = 1'b0; e_hit1 = 1'b0; e_way0 = 0; e_way1 = 0;
            end
            if (inv_all) begin
                clear_all();
                m_left = SETS;
            end else if (m_left > 0) begin
                m_left--;
            end else if (inv_line) begin
                for (int i = 0; i < WAYS; i++)
                    if (m_tag[i][set_of(adr)] == adr[31:12]) m_valid[i][set_of(adr)] = 1'b0;
            end else if (wr && adr[3:2] == 2'b11) begin
                m_tag[m_ptr[set_of(adr)]][set_of(adr)] = adr[31:12];
                m_valid[m_ptr[set_of(adr)]][set_of(adr)] = 1'b1;
                m_ptr[set_of(adr)] = (m_ptr[set_of(adr)] + 1) % WAYS;
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Per-cycle compare against the model.
    always @(negedge clk) begin
        if (rst_n === 1'b1) begin
            check("busy", 32'(busy), 32'(m_left > 0));
            check("hit0", 32'(hit0), 32'(e_hit0));
            check("hit0_way", 32'(hit0_way), 32'(e_way0));
            check("hit1", 32'(hit1), 32'(e_hit1));
            check("hit1_way", 32'(hit1_way), 32'(e_way1));
            if (m_left == 0) check("wr_way", 32'(wr_way), 32'(m_ptr[set_of(adr)]));
        end
    end

    task automatic step(input logic [31:0] p, input logic w, input logic [31:0] a,
                        input logic il, input logic ia);
        @(posedge clk);
        #2;
        pc = p; wr = w; adr = a; inv_line = il; inv_all = ia;
    endtask

    task automatic look(input logic [31:0] p);
        step(p, 1'b0, 32'h0, 1'b0, 1'b0);
    endtask

    task automatic chk(input string name, input logic h0, input int w0, input logic h1, input int w1);
        @(negedge clk);
        check({name, "_hit0"}, 32'(hit0), 32'(h0));
        check({name, "_way0"}, 32'(hit0_way), 32'(w0));
        check({name, "_hit1"}, 32'(hit1), 32'(h1));
        check({name, "_way1"}, 32'(hit1_way), 32'(w1));
    endtask

    task automatic count_busy(input string name);
        int n;
        n = 0;
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            if (!busy) break;
            n++;
        end
        check(name, 32'(n), 32'd256);
    endtask

    function automatic logic [31:0] rnd_addr();
        logic [19:0] tags [4];
        tags[0] = 20'h00000; tags[1] = 20'h00001; tags[2] = 20'hFFFFF; tags[3] = 20'h12345;
        return {tags[$urandom_range(0, 3)], 8'($urandom_range(8'h20, 8'h24)), 4'($urandom_range(0, 15))};
    endfunction

    initial begin
        rst_n = 1'b0; pc = '0; adr = '0; wr = 1'b0; inv_line = 1'b0; inv_all = 1'b0;
        repeat (3) @(posedge clk);
        #2 rst_n = 1'b1;
        count_busy("reset_sweep_len");

        for (int i = 0; i < 20; i++) look($urandom);

        // Round-robin fills into set 0x23.
        step(0, 1'b1, 32'h0000_123C, 1'b0, 1'b0);
        @(negedge clk); check("fill1_way", 32'(wr_way), 32'd0);
        look(32'h0000_1230); look(32'h0000_2230);
        chk("hit_1230", 1'b1, 0, 1'b1, 0);
        look(0);
        chk("miss_2230", 1'b0, 0, 1'b0, 0);
        step(0, 1'b1, 32'h0000_523C, 1'b0, 1'b0);
        @(negedge clk); check("fill2_way", 32'(wr_way), 32'd1);
        look(32'h0000_5230); look(32'h0000_1230);
        chk("hit_5230", 1'b1, 1, 1'b1, 1);
        look(0);
        chk("hit_1230_again", 1'b1, 0, 1'b1, 0);
        step(0, 1'b1, 32'h0000_923C, 1'b0, 1'b0);
        @(negedge clk); check("fill3_way", 32'(wr_way), 32'd0);
        look(32'h0000_1230); look(32'h0000_5230);
        chk("evicted_1230", 1'b0, 0, 1'b0, 0);
        look(32'h0000_9230);
        chk("kept_5230", 1'b1, 1, 1'b1, 1);
        look(0);
        chk("hit_9230", 1'b1, 0, 1'b1, 0);

        // Second lookup crossing into the next line, and wrap of pc+8.
        step(0, 1'b1, 32'h0000_333C, 1'b0, 1'b0);
        look(32'h0000_3338); look(0);
        chk("span_half", 1'b1, 0, 1'b0, 0);
        step(0, 1'b1, 32'h0000_334C, 1'b0, 1'b0);
        look(32'h0000_3338); look(0);
        chk("span_both", 1'b1, 0, 1'b1, 0);
        step(0, 1'b1, 32'h0000_4448, 1'b0, 1'b0);
        look(32'h0000_4440); look(0);
        chk("partial_wr", 1'b0, 0, 1'b0, 0);
        step(0, 1'b1, 32'h0000_000C, 1'b0, 1'b0);
        look(32'hFFFF_FFF8); look(0);
        chk("pcp_wrap", 1'b0, 0, 1'b1, 0);

        // Line invalidate with a concurrent lookup of the same line.
        step(32'h0000_5230, 1'b0, 32'h0000_5230, 1'b1, 1'b0);
        look(32'h0000_5230);
        chk("inv_same_cycle", 1'b1, 1, 1'b1, 1);
        look(32'h0000_9230);
        chk("inv_after", 1'b0, 0, 1'b0, 0);
        step(0, 1'b0, 32'h0000_523C, 1'b0, 1'b0);
        chk("inv_kept_9230", 1'b1, 0, 1'b1, 0);
        check("ptr_after_inv", 32'(wr_way), 32'd1);

        // Randomized traffic.
        for (int i = 0; i < 1500; i++) begin
            logic [31:0] p;
            p = ($urandom_range(0, 7) == 0) ? $urandom : rnd_addr();
            step(p, 1'($urandom_range(0, 2) == 0), rnd_addr(),
                 1'($urandom_range(0, 15) == 0), 1'($urandom_range(0, 399) == 0));
        end
        step(0, 1'b0, 0, 1'b0, 1'b0);
        for (int i = 0; i < 300 && busy; i++) step(0, 1'b0, 0, 1'b0, 1'b0);
        check("random_drain_idle", 32'(busy), 32'd0);

        // inv_all swallows simultaneous fill/invalidate, and restarts a running sweep.
        step(0, 1'b1, 32'h0000_123C, 1'b0, 1'b0);
        step(0, 1'b1, 32'h0000_888C, 1'b1, 1'b1);
        repeat (99) step(0, 1'b0, 0, 1'b0, 1'b0);
        step(0, 1'b1, 32'h0000_777C, 1'b1, 1'b1);
        step(0, 1'b0, 0, 1'b0, 1'b0);
        count_busy("restart_sweep_len");
        look(32'h0000_1230); look(32'h0000_8880);
        chk("swept_1230", 1'b0, 0, 1'b0, 0);
        look(32'h0000_7770);
        chk("dropped_888c", 1'b0, 0, 1'b0, 0);
        look(0);
        chk("dropped_777c", 1'b0, 0, 1'b0, 0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
